// File: rtl/soc_bus_pkg.sv
// Shared system-bus definitions: master port FSM states, default bus widths
// and error codes reserved for a future multi-bit rsp_err.
package soc_bus_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACCESS,
    ST_DONE
  } bus_state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_TIMEOUT,
    ERR_RETRY
  } bus_err_e;

endpackage

// File: rtl/bus_master_port_if.sv
// Client command/response handshake plus the arbiter and system bus signals
// of one master port; the master modport is the port side.
interface bus_master_port_if import soc_bus_pkg::*; #(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              m_req;
  logic              m_gnt;
  logic              bus_valid;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ready;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, m_gnt, bus_rdata, bus_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, m_req,
           bus_valid, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, m_gnt, bus_rdata, bus_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, m_req,
           bus_valid, bus_we, bus_addr, bus_wdata
  );

endinterface

// File: rtl/bus_master_port.sv
// Single-beat bus master port: requests the arbiter, drives the bus while granted,
// and handles wait states, grant loss and timeout before a one-cycle response.
module bus_master_port import soc_bus_pkg::*; #(
  parameter int ADDR_W      = BUS_ADDR_W,
  parameter int DATA_W      = BUS_DATA_W,
  parameter int TIMEOUT_CYC = 255,
  parameter int MAX_RETRY   = 3
) (
  input logic             clk,
  input logic             rst,
  bus_master_port_if.master port
);

  localparam int WAIT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST   = WAIT_W'(TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  bus_state_e         state_q, state_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               m_req_q, m_req_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;
  logic               bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]  bus_wdata_q, bus_wdata_d;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_cnt_d  = wait_cnt_q;
    retry_cnt_d = retry_cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_ready_q && port.cmd_valid) begin
          we_d        = port.cmd_we;
          addr_d      = port.cmd_addr;
          wdata_d     = port.cmd_wdata;
          wait_cnt_d  = '0;
          retry_cnt_d = '0;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (port.m_gnt) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        // wait_cnt survives a preemption, so the timeout bounds total granted wait per command
        if (port.m_gnt) begin
          if (port.bus_ready) begin
            rsp_rdata_d = we_q ? '0 : port.bus_rdata;
            rsp_err_d   = 1'b0;
            state_d     = ST_DONE;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
            if (wait_cnt_q == WAIT_LAST) begin
              rsp_rdata_d = '0;
              rsp_err_d   = 1'b1;
              state_d     = ST_DONE;
            end
          end
        end else if (retry_cnt_q == RETRY_LIMIT) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = ST_DONE;
        end else begin
          retry_cnt_d = retry_cnt_q + 1'b1;
          state_d     = ST_REQ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state they describe
    cmd_ready_d = (state_d == ST_IDLE);
    m_req_d     = (state_d == ST_REQ) || (state_d == ST_ACCESS);
    rsp_valid_d = (state_d == ST_DONE);
    bus_we_d    = (state_d == ST_ACCESS) && we_d;
    bus_addr_d  = (state_d == ST_ACCESS) ? addr_d  : '0;
    bus_wdata_d = (state_d == ST_ACCESS) ? wdata_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_cnt_q  <= '0;
      retry_cnt_q <= '0;
      cmd_ready_q <= 1'b0;
      m_req_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      m_req_q     <= m_req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Gated by the live grant so the bus is released in the same cycle the arbiter takes it away
  assign port.bus_valid = (state_q == ST_ACCESS) && port.m_gnt;
  assign port.cmd_ready = cmd_ready_q;
  assign port.m_req     = m_req_q;
  assign port.rsp_valid = rsp_valid_q;
  assign port.rsp_rdata = rsp_rdata_q;
  assign port.rsp_err   = rsp_err_q;
  assign port.bus_we    = bus_we_q;
  assign port.bus_addr  = bus_addr_q;
  assign port.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: each command carries hand-derived grant/ready
// scripts and the cycle-by-cycle bus_valid and response timing it must produce.
module tb_bus_master_port;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_master_port_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

  logic gnt_follow;
  logic gnt_drv;
  assign bif.m_gnt = gnt_follow ? bif.m_req : gnt_drv;

  bus_master_port #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(16), .MAX_RETRY(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .port(bif.master)
  );

  int cyc = 0;
  int tests_run = 0;
  int tests_failed = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected behaviour of the outstanding command, relative to its accept cycle
  logic          started, busy, after_rst;
  int            acc_cyc, rsp_off, off;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, exp_rdata, last_rdata;
  logic          exp_err, last_err;
  logic [63:0]   gseq, rseq, bvseq;
  logic          in_win, at_rsp;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
               name, cyc, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (started && !rst) begin
      off    = busy ? (cyc - acc_cyc) : 0;
      in_win = busy && (off >= 1) && (off < rsp_off);
      at_rsp = busy && (off == rsp_off);
      checkOutput("cmd_ready", 64'(bif.cmd_ready), 64'((!busy || off == 0) && !after_rst));
      checkOutput("m_req", 64'(bif.m_req), 64'(in_win));
      checkOutput("rsp_valid", 64'(bif.rsp_valid), 64'(at_rsp));
      checkOutput("bus_valid", 64'(bif.bus_valid), 64'(in_win && bvseq[off]));
      if (bif.bus_valid) begin
        checkOutput("bus_addr", 64'(bif.bus_addr), 64'(m_addr));
        checkOutput("bus_we", 64'(bif.bus_we), 64'(m_we));
        checkOutput("bus_wdata", 64'(bif.bus_wdata), 64'(m_wdata));
      end
      if (!in_win) begin
        checkOutput("bus_addr_idle", 64'(bif.bus_addr), 64'd0);
        checkOutput("bus_we_idle", 64'(bif.bus_we), 64'd0);
        checkOutput("bus_wdata_idle", 64'(bif.bus_wdata), 64'd0);
      end
      checkOutput("rsp_rdata", 64'(bif.rsp_rdata), 64'(at_rsp ? exp_rdata : last_rdata));
      checkOutput("rsp_err", 64'(bif.rsp_err), 64'(at_rsp ? exp_err : last_err));
    end
  end

  // Waits for the port to be idle and presents a command during cycle 0
  task automatic startCmd(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
    int n = 0;
    while (!bif.cmd_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bif.cmd_ready) checkOutput("cmd_ready_wait", 64'd0, 64'd1);
    acc_cyc       = cyc;
    m_we          = we;
    m_addr        = addr;
    m_wdata       = wdata;
    busy          = 1'b1;
    bif.cmd_valid = 1'b1;
    bif.cmd_we    = we;
    bif.cmd_addr  = addr;
    bif.cmd_wdata = wdata;
    bif.bus_rdata = rdata;
    gnt_drv       = 1'b0;
    bif.bus_ready = 1'b0;
  endtask

  task automatic applyStimulus(input string name, input logic we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                               input logic follow, input logic [63:0] gs, input logic [63:0] rs,
                               input logic [63:0] bvs, input int roff,
                               input logic [DW-1:0] erdata, input logic eerr);
    $display("[TB] %s", name);
    gseq      = gs;
    rseq      = rs;
    bvseq     = bvs;
    rsp_off   = roff;
    exp_rdata = erdata;
    exp_err   = eerr;
    startCmd(we, addr, wdata, rdata);
    for (int k = 1; k <= roff; k++) begin
      @(posedge clk); #1;
      bif.cmd_valid = 1'b0;
      gnt_follow    = follow;
      gnt_drv       = gseq[k];
      bif.bus_ready = rseq[k];
    end
    @(posedge clk); #1;
    busy          = 1'b0;
    last_rdata    = erdata;
    last_err      = eerr;
    gnt_follow    = 1'b0;
    gnt_drv       = 1'b0;
    bif.bus_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    started = 1'b0; busy = 1'b0; after_rst = 1'b0;
    gnt_follow = 1'b0; gnt_drv = 1'b0;
    bif.cmd_valid = 1'b0; bif.cmd_we = 1'b0; bif.cmd_addr = '0; bif.cmd_wdata = '0;
    bif.bus_rdata = '0; bif.bus_ready = 1'b0;
    acc_cyc = 0; rsp_off = 0; off = 0;
    m_we = 1'b0; m_addr = '0; m_wdata = '0;
    exp_rdata = '0; exp_err = 1'b0; last_rdata = '0; last_err = 1'b0;
    gseq = '0; rseq = '0; bvseq = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0; after_rst = 1'b1; started = 1'b1;
    checkOutput("reset_cmd_ready", 64'(bif.cmd_ready), 64'd0);
    checkOutput("reset_m_req", 64'(bif.m_req), 64'd0);
    checkOutput("reset_rsp_valid", 64'(bif.rsp_valid), 64'd0);
    @(posedge clk); #1 after_rst = 1'b0;
    checkOutput("ready_after_reset", 64'(bif.cmd_ready), 64'd1);

    applyStimulus("zero-wait read", 1'b0, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 1'b1,
                  64'h0, '1, 64'h4, 3, 32'hDEAD_BEEF, 1'b0);
    repeat (2) @(posedge clk);
    #1 checkOutput("hold_rdata", 64'(bif.rsp_rdata), 64'hDEAD_BEEF);

    applyStimulus("delayed grant", 1'b0, 32'h1000_0008, 32'h0, 32'h1234_5678, 1'b0,
                  64'h1C0, '1, 64'h80, 8, 32'h1234_5678, 1'b0);

    applyStimulus("preemption", 1'b1, 32'h2000_0010, 32'hA5A5_A5A5, 32'hFFFF_0000, 1'b0,
                  64'hE6, 64'h40, 64'h44, 7, 32'h0, 1'b0);

    applyStimulus("one wait state", 1'b0, 32'h1000_0040, 32'h0, 32'h0123_4567, 1'b0,
                  64'hFFFF_FFFF_FFFF_FFFE, 64'h8, 64'hC, 4, 32'h0123_4567, 1'b0);

    applyStimulus("timeout", 1'b0, 32'h3000_0000, 32'h0, 32'hFFFF_FFFF, 1'b0,
                  64'h7FFFE, 64'h0, 64'h3FFFC, 18, 32'h0, 1'b1);
    checkOutput("timeout_err_held", 64'(bif.rsp_err), 64'd1);
    checkOutput("timeout_rdata_zero", 64'(bif.rsp_rdata), 64'd0);

    applyStimulus("retry limit", 1'b1, 32'h4000_0020, 32'h0BAD_F00D, 32'h0, 1'b0,
                  64'h5B6, 64'h0, 64'h124, 10, 32'h0, 1'b1);

    applyStimulus("read before reset", 1'b0, 32'h1000_0080, 32'h0, 32'h7654_3210, 1'b1,
                  64'h0, '1, 64'h4, 3, 32'h7654_3210, 1'b0);

    $display("[TB] reset mid-access");
    gseq = '1; rseq = '0; bvseq = 64'hC; rsp_off = 63;
    exp_rdata = '0; exp_err = 1'b0;
    startCmd(1'b0, 32'h5000_0000, 32'h0, 32'h1111_2222);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      bif.cmd_valid = 1'b0;
      gnt_drv = 1'b1;
      if (k == 3) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0; busy = 1'b0; after_rst = 1'b1;
    last_rdata = '0; last_err = 1'b0;
    bif.bus_ready = 1'b1;
    checkOutput("rst_m_req", 64'(bif.m_req), 64'd0);
    checkOutput("rst_bus_valid", 64'(bif.bus_valid), 64'd0);
    checkOutput("rst_rsp_valid", 64'(bif.rsp_valid), 64'd0);
    checkOutput("rst_rsp_rdata", 64'(bif.rsp_rdata), 64'd0);
    @(posedge clk); #1;
    after_rst = 1'b0; gnt_drv = 1'b0; bif.bus_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    applyStimulus("read after reset", 1'b0, 32'h7000_0000, 32'h0, 32'h0F0F_0F0F, 1'b1,
                  64'h0, '1, 64'h4, 3, 32'h0F0F_0F0F, 1'b0);

    applyStimulus("zero-wait write", 1'b1, 32'h6000_0004, 32'h1357_9BDF, 32'hCAFE_F00D, 1'b1,
                  64'h0, '1, 64'h4, 3, 32'h0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
